round_unit_pipe: RTL and testbench
==================================

Name: round_unit_pipe

Overview:
- Parametrised, pipelined, multi-mode rounding unit for the divider/sqrt datapath.
- Takes a raw quotient carrying GUARD extra low bits, plus the final remainder's sign and zero status.
- Produces the correctly rounded magnitude under five IEEE-style modes, with inexact and overflow flags.
- Two-stage valid/ready pipeline; sits between the iteration engine and the result packer.

Parameters:
WIDTH, 28, width of raw quotient x including guard bits
GUARD, 4, number of guard bits below the result LSB (must be >= 2)
OUT_W, WIDTH-GUARD, derived result width (localparam, not overridable)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  unit can accept a beat this cycle
x  input  WIDTH  raw unsigned quotient magnitude with GUARD low bits
sign  input  1  sign of the result (1 = negative); used by directed modes
rem_neg  input  1  final remainder negative (x overestimates the true value)
rem_zero  input  1  final remainder exactly zero
mode  input  3  round_mode_t: RNE=0, RZ=1, RDN=2, RUP=3, RMM=4
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts the result
y  output  OUT_W  rounded magnitude
inexact  output  1  result differs from the true value
overflow  output  1  rounding increment carried out of OUT_W bits (y wraps to 0)

Behaviour:
- True value T, in units of x's LSB:
  - rem_zero: T = x.
  - rem_neg (and not rem_zero): x-1 < T < x.
  - Otherwise: x < T < x+1.
- rem_zero overrides rem_neg.
- Stage 1 (normalise/decide):
  - xe = rem_neg&~rem_zero ? x-1 : x.
  - st0 = ~rem_zero.
  - keep = xe[WIDTH-1:GUARD]; r = xe[GUARD-1]; s = |xe[GUARD-2:0] | st0.
  - inc per mode:
    - RNE: r&(s|keep[0])
    - RZ: 0
    - RDN: sign&(r|s)
    - RUP: ~sign&(r|s)
    - RMM: r
  - Registers keep, inc, inexact = r|s.
- Stage 2 (increment): {carry,y} = keep + inc; overflow = carry; registers y, inexact, overflow.
- Invalid mode codes 5-7 behave as RZ.
- x==0 with rem_neg&~rem_zero is illegal upstream; the RTL carries a simulation assertion. Data behaviour is then don't-care, but the handshake must be unaffected.
- Handshake:
  - A beat transfers when valid&ready are high on a rising edge.
  - Each stage holds one beat and advances when the next stage is empty or draining in the same cycle.
  - in_ready = ~s1_valid | s1_adv; s1_adv = ~s2_valid | out_ready.
  - Full throughput of 1 beat/cycle with out_ready high; latency exactly 2 cycles from input accept to out_valid.
- Outputs are stable while out_valid&~out_ready (no change, no drop, no duplicate).
- in_ready does not depend combinationally on in_valid; it may depend on out_ready.
- Reset (async assert, sync deassert handled outside):
  - out_valid=0, y=0, inexact=0, overflow=0.
  - Both stage valids cleared; any in-flight beats are discarded.
  - in_ready=1 the cycle after reset deasserts.
- Simultaneous accept into a full pipe while out_ready=1: all beats shift; no bubble.

Decomposition:
- round_pkg:
  - typedef enum logic [2:0] round_mode_t {RNE, RZ, RDN, RUP, RMM}.
  - Function mode_is_directed().
- Sub-module round_decide: purely combinational.
  - Inputs: xe tail bits, keep[0], sign, st0, mode.
  - Outputs: inc, inexact.
  - Unit-testable exhaustively for GUARD=4.
- round_unit_pipe instantiates round_decide in stage 1 and holds all pipeline registers and handshake logic.

Test Plan (WIDTH=28, GUARD=4, out_ready=1 unless stated):
- Tie to even: x=0x0000018, rem_zero=1, RNE -> y=0x000002, inexact=1, overflow=0. x=0x0000028 same -> y=0x000002. x=0x0000028 rem_zero=0, rem_neg=0 -> y=0x000003.
- Remainder negative: x=0x0000020, rem_neg=1, RZ -> y=0x000001, inexact=1. Same input with RNE -> y=0x000002.
- Directed modes: x=0x0000021, rem_zero=1:
  - RUP, sign=0 -> y=3.
  - RUP, sign=1 -> y=2.
  - RDN, sign=1 -> y=3.
  - RMM with x=0x0000028 -> y=3.
  - Exact x=0x0000030, rem_zero=1, any mode -> y=3, inexact=0.
- Overflow: x=0xFFFFFF8, rem_zero=1, RNE -> y=0x000000, overflow=1, inexact=1.
- Backpressure: stream 6 beats back-to-back, hold out_ready=0 for cycles 3-6.
  - in_ready falls after 2 beats are held.
  - Outputs stay stable while stalled.
  - All 6 results appear in order, none lost or duplicated.
  - First out_valid arrives exactly 2 cycles after the first accept.
- Reset mid-stream: assert rst_n=0 with both stages full -> out_valid=0 and y=0 immediately. After release, no stale beat emerges and the next input produces its correct result 2 cycles later.

Source files
------------

// File: rtl/round_pkg.sv
// Shared types and helpers for the pipelined rounding unit.
package round_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RZ  = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } round_mode_t;

    localparam int unsigned MIN_GUARD = 2;

    // Directed modes are the only ones whose decision depends on the result sign.
    function automatic logic mode_is_directed(input logic [2:0] mode);
        logic directed;
        directed = 1'b0;
        case (mode)
            RDN, RUP: directed = 1'b1;
            default:  directed = 1'b0;
        endcase
        return directed;
    endfunction

endpackage

// File: rtl/round_unit_pipe_if.sv
// Beat-level handshake and data bundle between the iteration engine, the rounder and the packer.
interface round_unit_pipe_if #(
    parameter int WIDTH = 28,
    parameter int GUARD = 4
) ();
    localparam int OUT_W = WIDTH - GUARD;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic             sign;
    logic             rem_neg;
    logic             rem_zero;
    logic [2:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] y;
    logic             inexact;
    logic             overflow;

    modport master (
        output in_valid, x, sign, rem_neg, rem_zero, mode, out_ready,
        input  in_ready, out_valid, y, inexact, overflow
    );

    modport slave (
        input  in_valid, x, sign, rem_neg, rem_zero, mode, out_ready,
        output in_ready, out_valid, y, inexact, overflow
    );

endinterface

// File: rtl/round_decide.sv
// Combinational rounding decision: from the tail bits below the result LSB, pick increment and inexact.
module round_decide
    import round_pkg::*;
#(
    parameter int GUARD = 4
) (
    input  logic [GUARD-1:0] tail,
    input  logic             keep_lsb,
    input  logic             sign,
    input  logic             st0,
    input  logic [2:0]       mode,
    output logic             inc,
    output logic             inexact
);

    logic round_bit_s;
    logic sticky_s;

    assign round_bit_s = tail[GUARD-1];
    assign sticky_s    = (|tail[GUARD-2:0]) | st0;
    assign inexact     = round_bit_s | sticky_s;

    // Mode table; unknown codes truncate like RZ.
    always_comb begin
        inc = 1'b0;
        if (mode_is_directed(mode)) begin
            inc = (round_bit_s | sticky_s) & ((mode == RDN) ? sign : ~sign);
        end else begin
            case (mode)
                RNE:     inc = round_bit_s & (sticky_s | keep_lsb);
                RMM:     inc = round_bit_s;
                RZ:      inc = 1'b0;
                default: inc = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/round_unit_pipe_chk.sv
// Simulation-only protocol checks for the rounding pipeline.
module round_unit_pipe_chk #(
    parameter int WIDTH = 28,
    parameter int GUARD = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic                   in_valid,
    input logic                   in_ready,
    input logic [WIDTH-1:0]       x,
    input logic                   rem_neg,
    input logic                   rem_zero,
    input logic                   out_valid,
    input logic                   out_ready,
    input logic [WIDTH-GUARD-1:0] y,
    input logic                   inexact,
    input logic                   overflow
);

    logic in_fire_s;

    assign in_fire_s = in_valid & in_ready;

    // A zero quotient with a negative remainder would imply a negative true value.
    a_no_zero_neg: assert property (@(posedge clk) disable iff (!rst_n)
        in_fire_s |-> !((x == {WIDTH{1'b0}}) && rem_neg && !rem_zero));

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(y) && $stable(inexact) && $stable(overflow)));

    a_ready_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        (!out_valid && out_ready) |-> in_ready);

endmodule

// File: rtl/round_unit_pipe.sv
// Two-stage valid/ready rounding pipeline: stage 1 decides the increment, stage 2 applies it.
module round_unit_pipe
    import round_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int GUARD = 4
) (
    input logic          clk,
    input logic          rst_n,
    round_unit_pipe_if.slave bus
);

    localparam int OUT_W = WIDTH - GUARD;

    logic [WIDTH-1:0] xe_s;
    logic             st0_s;
    logic             dec_inc_s;
    logic             dec_inexact_s;
    logic             s1_adv_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [OUT_W:0]   sum_s;

    logic             s1_valid_r;
    logic [OUT_W-1:0] s1_keep_r;
    logic             s1_inc_r;
    logic             s1_inexact_r;

    logic             s2_valid_r;
    logic [OUT_W-1:0] s2_y_r;
    logic             s2_inexact_r;
    logic             s2_overflow_r;

    // A negative remainder means x overshoots: step down one LSB so the tail sees the truncated value.
    assign xe_s  = (bus.rem_neg & ~bus.rem_zero) ? (bus.x - {{(WIDTH-1){1'b0}}, 1'b1}) : bus.x;
    assign st0_s = ~bus.rem_zero;

    round_decide #(
        .GUARD (GUARD)
    ) u_decide (
        .tail     (xe_s[GUARD-1:0]),
        .keep_lsb (xe_s[GUARD]),
        .sign     (bus.sign),
        .st0      (st0_s),
        .mode     (bus.mode),
        .inc      (dec_inc_s),
        .inexact  (dec_inexact_s)
    );

    assign s1_adv_s   = ~s2_valid_r | bus.out_ready;
    assign in_ready_s = ~s1_valid_r | s1_adv_s;
    assign accept_s   = bus.in_valid & in_ready_s;
    assign sum_s      = {1'b0, s1_keep_r} + {{OUT_W{1'b0}}, s1_inc_r};

    // Stage 1: capture the truncated result and the rounding decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r   <= 1'b0;
            s1_keep_r    <= {OUT_W{1'b0}};
            s1_inc_r     <= 1'b0;
            s1_inexact_r <= 1'b0;
        end else begin
            if (in_ready_s) begin
                s1_valid_r <= bus.in_valid;
            end
            if (accept_s) begin
                s1_keep_r    <= xe_s[WIDTH-1:GUARD];
                s1_inc_r     <= dec_inc_s;
                s1_inexact_r <= dec_inexact_s;
            end
        end
    end

    // Stage 2: apply the increment; data only moves with a real beat so stalled outputs stay put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r    <= 1'b0;
            s2_y_r        <= {OUT_W{1'b0}};
            s2_inexact_r  <= 1'b0;
            s2_overflow_r <= 1'b0;
        end else begin
            if (s1_adv_s) begin
                s2_valid_r <= s1_valid_r;
            end
            if (s1_adv_s & s1_valid_r) begin
                s2_y_r        <= sum_s[OUT_W-1:0];
                s2_inexact_r  <= s1_inexact_r;
                s2_overflow_r <= sum_s[OUT_W];
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.y         = s2_y_r;
    assign bus.inexact   = s2_inexact_r;
    assign bus.overflow  = s2_overflow_r;

    round_unit_pipe_chk #(
        .WIDTH (WIDTH),
        .GUARD (GUARD)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (in_ready_s),
        .x         (bus.x),
        .rem_neg   (bus.rem_neg),
        .rem_zero  (bus.rem_zero),
        .out_valid (s2_valid_r),
        .out_ready (bus.out_ready),
        .y         (s2_y_r),
        .inexact   (s2_inexact_r),
        .overflow  (s2_overflow_r)
    );

endmodule

// File: tb/tb_round_unit_pipe.sv
// Scoreboard bench for round_unit_pipe: directed spec cases plus randomized traffic against an arithmetic model.
module tb_round_unit_pipe;
    import round_pkg::*;

    localparam int WIDTH = 28;
    localparam int GUARD = 4;
    localparam int OUT_W = WIDTH - GUARD;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    round_unit_pipe_if #(.WIDTH(WIDTH), .GUARD(GUARD)) bus ();

    round_unit_pipe #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [OUT_W+1:0] exp_q[$];
    bit stream_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: true value in half-LSB units of x, rounded to multiples of 2^(GUARD+1).
    function automatic logic [OUT_W+1:0] model(input logic [WIDTH-1:0] xv, input logic sg,
                                               input logic rn, input logic rz, input logic [2:0] md);
        longint unit, half, t2, q, rem, res;
        bit up;
        logic ovf, inx;
        logic [OUT_W-1:0] yv;
        unit = longint'(1) << (GUARD + 1);
        half = unit / 2;
        if (rz)      t2 = 2 * longint'(xv);
        else if (rn) t2 = 2 * longint'(xv) - 1;
        else         t2 = 2 * longint'(xv) + 1;
        q   = t2 / unit;
        rem = t2 % unit;
        case (md)
            3'd0:    up = (rem > half) || ((rem == half) && (q % 2 == 1));
            3'd2:    up = sg && (rem != 0);
            3'd3:    up = !sg && (rem != 0);
            3'd4:    up = (rem >= half);
            default: up = 1'b0;
        endcase
        res = q + (up ? 1 : 0);
        ovf = (res >= (longint'(1) << OUT_W));
        inx = (rem != 0);
        yv  = res[OUT_W-1:0];
        return {ovf, inx, yv};
    endfunction

    task automatic send(input logic [WIDTH-1:0] xv, input logic sg, input logic rn, input logic rz,
                        input logic [2:0] md, input logic [OUT_W+1:0] ev);
        int n;
        @(negedge clk);
        bus.x        = xv;
        bus.sign     = sg;
        bus.rem_neg  = rn;
        bus.rem_zero = rz;
        bus.mode     = md;
        bus.in_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
            bus.in_valid = 1'b0;
        end else begin
            exp_q.push_back(ev);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic send_model(input logic [WIDTH-1:0] xv, input logic sg, input logic rn,
                              input logic rz, input logic [2:0] md);
        send(xv, sg, rn, rz, md, model(xv, sg, rn, rz, md));
    endtask

    task automatic send_random();
        logic [WIDTH-1:0] xv;
        logic rn, rz;
        case ($urandom_range(0, 3))
            0:       xv = 28'hFFFFFFF - WIDTH'($urandom_range(0, 40));
            1:       xv = WIDTH'($urandom_range(0, 100));
            default: xv = WIDTH'($urandom);
        endcase
        rz = ($urandom_range(0, 2) == 0);
        rn = $urandom_range(0, 1) == 1;
        if (xv == '0 && rn && !rz) rz = 1'b1;
        send_model(xv, $urandom_range(0, 1) == 1, rn, rz, 3'($urandom_range(0, 7)));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: compares on each transfer and watches stalled outputs for changes or drops.
    logic [OUT_W+1:0] held;
    logic [OUT_W+1:0] cur;
    bit held_v = 1'b0;
    always @(negedge clk) begin
        #2;
        cur = {bus.overflow, bus.inexact, bus.y};
        if (!rst_n) begin
            held_v = 1'b0;
        end else if (bus.out_valid) begin
            if (held_v) check("stall_stable", 64'(cur), 64'(held));
            if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", cur);
                end else begin
                    check("result{ovf,inx,y}", 64'(cur), 64'(exp_q.pop_front()));
                end
                held_v = 1'b0;
            end else begin
                held   = cur;
                held_v = 1'b1;
            end
        end else if (held_v) begin
            checks++;
            errors++;
            $display("FAIL stall_drop: out_valid=0 while held, required 1");
            held_v = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.sign      = 1'b0;
        bus.rem_neg   = 1'b0;
        bus.rem_zero  = 1'b1;
        bus.mode      = 3'd0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out", 64'({bus.out_valid, bus.overflow, bus.inexact, bus.y}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed cases with hand-derived expectations {overflow, inexact, y}.
        send(28'h0000018, 1'b0, 1'b0, 1'b1, RNE, {1'b0, 1'b1, 24'h000002});
        send(28'h0000028, 1'b0, 1'b0, 1'b1, RNE, {1'b0, 1'b1, 24'h000002});
        send(28'h0000028, 1'b0, 1'b0, 1'b0, RNE, {1'b0, 1'b1, 24'h000003});
        send(28'h0000020, 1'b0, 1'b1, 1'b0, RZ,  {1'b0, 1'b1, 24'h000001});
        send(28'h0000020, 1'b0, 1'b1, 1'b0, RNE, {1'b0, 1'b1, 24'h000002});
        send(28'h0000021, 1'b0, 1'b0, 1'b1, RUP, {1'b0, 1'b1, 24'h000003});
        send(28'h0000021, 1'b1, 1'b0, 1'b1, RUP, {1'b0, 1'b1, 24'h000002});
        send(28'h0000021, 1'b1, 1'b0, 1'b1, RDN, {1'b0, 1'b1, 24'h000003});
        send(28'h0000028, 1'b0, 1'b0, 1'b1, RMM, {1'b0, 1'b1, 24'h000003});
        for (int m = 0; m < 8; m++) begin
            send(28'h0000030, m[0], 1'b0, 1'b1, 3'(m), {1'b0, 1'b0, 24'h000003});
        end
        send(28'hFFFFFF8, 1'b0, 1'b0, 1'b1, RNE, {1'b1, 1'b1, 24'h000000});
        drain();

        // Backpressure: six back-to-back beats, out_ready low in cycles 3..6.
        fork
            begin
                for (int i = 0; i < 6; i++) send_random();
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    @(negedge clk);
                    bus.out_ready = !(c >= 3 && c <= 6);
                    #3;
                    if (c == 1) check("latency_early_valid", 64'(bus.out_valid), 64'd0);
                    if (c == 2) check("latency_valid", 64'(bus.out_valid), 64'd1);
                    if (c >= 3 && c <= 6) check("in_ready_stall", 64'(bus.in_ready), 64'd0);
                end
            end
        join
        drain();

        // Reset with both stages full: outputs clear at once and nothing stale survives.
        @(negedge clk);
        bus.out_ready = 1'b0;
        send_model(28'h0123458, 1'b0, 1'b0, 1'b0, RNE);
        send_model(28'h0ABCDE7, 1'b1, 1'b1, 1'b0, RDN);
        @(negedge clk);
        #1;
        check("pre_reset_full", 64'({bus.out_valid, bus.in_ready}), 64'b10);
        rst_n = 1'b0;
        #1;
        check("reset_async_out", 64'({bus.out_valid, bus.y}), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #3;
            check("no_stale_beat", 64'(bus.out_valid), 64'd0);
        end
        send_model(28'h0000058, 1'b0, 1'b0, 1'b1, RNE);
        drain();

        // Randomized traffic with random gaps and random backpressure.
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    else send_random();
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 9) < 7);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
